mdu_seq: RTL and testbench

MDU_SEQ -- requirements
Module: mdu_seq

---
 rtl/mdu_pkg.sv | 38 +++
 rtl/mdu_shift_unit.sv | 94 +++++++++
 rtl/mdu_seq.sv | 179 +++++++++++++++++
 tb/tb_mdu_seq.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the sequential multiply/divide unit.
//   - MduDataWidth : default operand/result width
//   - op_e         : RV32M funct3 operation encodings
//   - St*          : FSM state encodings
//   - op_*_signed  : which operands an op treats as two's complement
// Optional feature macro: MDU_DIV_EN (divider path; see mdu_seq).
package mdu_pkg;

  localparam int unsigned MduDataWidth = 32;

  typedef enum logic [2:0] {
    OpMul    = 3'b000,
    OpMulh   = 3'b001,
    OpMulhsu = 3'b010,
    OpMulhu  = 3'b011,
    OpDiv    = 3'b100,
    OpDivu   = 3'b101,
    OpRem    = 3'b110,
    OpRemu   = 3'b111
  } op_e;

  // FSM state encodings, kept as plain constants for legacy compatibility.
  typedef logic [2:0] state_t;
  localparam state_t StIdle  = 3'd0;
  localparam state_t StPrep  = 3'd1;
  localparam state_t StCalc  = 3'd2;
  localparam state_t StFixup = 3'd3;
  localparam state_t StDone  = 3'd4;

  function automatic logic op_a_signed(op_e o);
    return o inside {OpMulh, OpMulhsu, OpDiv, OpRem};
  endfunction

  function automatic logic op_b_signed(op_e o);
    return o inside {OpMulh, OpDiv, OpRem};
  endfunction

endpackage

// File: rtl/mdu_shift_unit.sv
// mdu_shift_unit: combined {hi, lo} shift register with a shared adder/subtractor.
// Multiply: lo holds the multiplier, hi accumulates; one shift-add per step.
// Divide (only with MDU_DIV_EN): lo holds the dividend and collects quotient bits,
// hi holds the partial remainder; one restoring shift-subtract per step.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   load         : load magnitudes (mag_a, mag_b) and clear the accumulator
//   step         : perform one iteration
//   is_div       : operation kind sampled on load
//   mag_a, mag_b : unsigned operand magnitudes
//   hi, lo       : high/low halves (product, or remainder/quotient)
module mdu_shift_unit #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  step,
  input  logic                  is_div,
  input  logic [DATA_WIDTH-1:0] mag_a,
  input  logic [DATA_WIDTH-1:0] mag_b,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo
);

  logic [DATA_WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, addend_q, addend_d;
  logic [DATA_WIDTH:0]   sum;

`ifdef MDU_DIV_EN
  logic                is_div_q, is_div_d;
  logic [DATA_WIDTH:0] shifted, diff;
`else
  logic unused_is_div;
  assign unused_is_div = is_div;
`endif

  always_comb begin
    hi_d     = hi_q;
    lo_d     = lo_q;
    addend_d = addend_q;
    sum      = {1'b0, hi_q} + (lo_q[0] ? {1'b0, addend_q} : '0);
`ifdef MDU_DIV_EN
    is_div_d = is_div_q;
    shifted  = {hi_q, lo_q[DATA_WIDTH-1]};
    diff     = shifted - {1'b0, addend_q};
    if (load) begin
      is_div_d = is_div;
      hi_d     = '0;
      lo_d     = is_div ? mag_a : mag_b;
      addend_d = is_div ? mag_b : mag_a;
    end else if (step) begin
      if (is_div_q) begin
        // Restore (keep shifted value) when the trial subtraction went negative.
        hi_d = diff[DATA_WIDTH] ? shifted[DATA_WIDTH-1:0] : diff[DATA_WIDTH-1:0];
        lo_d = {lo_q[DATA_WIDTH-2:0], ~diff[DATA_WIDTH]};
      end else begin
        hi_d = sum[DATA_WIDTH:1];
        lo_d = {sum[0], lo_q[DATA_WIDTH-1:1]};
      end
    end
`else
    if (load) begin
      hi_d     = '0;
      lo_d     = mag_b;
      addend_d = mag_a;
    end else if (step) begin
      hi_d = sum[DATA_WIDTH:1];
      lo_d = {sum[0], lo_q[DATA_WIDTH-1:1]};
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q     <= '0;
      lo_q     <= '0;
      addend_q <= '0;
`ifdef MDU_DIV_EN
      is_div_q <= 1'b0;
`endif
    end else begin
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      addend_q <= addend_d;
`ifdef MDU_DIV_EN
      is_div_q <= is_div_d;
`endif
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: rtl/mdu_seq.sv
// mdu_seq: sequential RV32M multiply/divide unit (one result bit per cycle).
// Define MDU_DIV_EN to build the divider; otherwise divide ops report illegal.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   start, op         : request and funct3 operation (sampled only when ready)
//   op_a, op_b        : rs1 / rs2 operands
//   ready, busy       : idle indication and its complement (execute-stage stall)
//   done              : one-cycle result-valid pulse
//   result            : result, held until the next done
//   illegal           : pulses with done for an unsupported op
module mdu_seq import mdu_pkg::*; #(
  parameter int unsigned DATA_WIDTH = MduDataWidth
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [2:0]            op,
  input  logic [DATA_WIDTH-1:0] op_a,
  input  logic [DATA_WIDTH-1:0] op_b,
  output logic                  ready,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  illegal
);

  localparam int unsigned CntW  = $clog2(DATA_WIDTH) + 1;
  localparam int unsigned ProdW = 2 * DATA_WIDTH;

  state_t                state_q, state_d;
  op_e                   op_q, op_d;
  logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  neg_q, neg_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic                  illegal_q, illegal_d;
`ifdef MDU_DIV_EN
  logic                  div0_q, div0_d;
`endif

  logic                  a_neg, b_neg, op_illegal, load, step;
  logic [DATA_WIDTH-1:0] mag_a, mag_b, hi, lo, fix_result;
  logic [ProdW-1:0]      prod, prod_fix;

  // Magnitudes of the latched operands, consumed by the shift unit in PREP.
  always_comb begin
    a_neg = op_a_signed(op_q) & a_q[DATA_WIDTH-1];
    b_neg = op_b_signed(op_q) & b_q[DATA_WIDTH-1];
    mag_a = a_neg ? -a_q : a_q;
    mag_b = b_neg ? -b_q : b_q;
  end

`ifdef MDU_DIV_EN
  assign op_illegal = 1'b0;
`else
  assign op_illegal = op_q[2];
`endif

  mdu_shift_unit #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_shift (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (load),
    .step   (step),
    .is_div (op_q[2]),
    .mag_a  (mag_a),
    .mag_b  (mag_b),
    .hi     (hi),
    .lo     (lo)
  );

  // Sign correction and word select.
  always_comb begin
    prod       = {hi, lo};
    prod_fix   = neg_q ? -prod : prod;
    fix_result = '0;
    case (op_q)
      OpMul:                     fix_result = prod_fix[DATA_WIDTH-1:0];
      OpMulh, OpMulhsu, OpMulhu: fix_result = prod_fix[ProdW-1:DATA_WIDTH];
`ifdef MDU_DIV_EN
      OpDiv, OpDivu:             fix_result = div0_q ? '1 : (neg_q ? -lo : lo);
      OpRem, OpRemu:             fix_result = div0_q ? a_q : (neg_q ? -hi : hi);
`endif
      default:                   fix_result = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    result_d  = result_q;
    illegal_d = illegal_q;
    load      = 1'b0;
    step      = 1'b0;
`ifdef MDU_DIV_EN
    div0_d    = div0_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          op_d = op_e'(op);
          a_d  = op_a;
          b_d  = op_b;
`ifdef MDU_DIV_EN
          state_d = StPrep;
`else
          // Unsupported ops skip the datapath; FIXUP forces result 0 and illegal.
          state_d = op[2] ? StFixup : StPrep;
`endif
        end
      end
      StPrep: begin
        load    = 1'b1;
        cnt_d   = '0;
        // The remainder follows the dividend's sign; everything else is a xor b.
        neg_d   = (op_q inside {OpRem, OpRemu}) ? a_neg : (a_neg ^ b_neg);
`ifdef MDU_DIV_EN
        div0_d  = (b_q == '0);
`endif
        state_d = StCalc;
      end
      StCalc: begin
        step  = 1'b1;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(DATA_WIDTH - 1)) state_d = StFixup;
      end
      StFixup: begin
        result_d  = op_illegal ? '0 : fix_result;
        illegal_d = op_illegal;
        state_d   = StDone;
      end
      StDone: begin
        illegal_d = 1'b0;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      op_q      <= OpMul;
      a_q       <= '0;
      b_q       <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      result_q  <= '0;
      illegal_q <= 1'b0;
`ifdef MDU_DIV_EN
      div0_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      cnt_q     <= cnt_d;
      neg_q     <= neg_d;
      result_q  <= result_d;
      illegal_q <= illegal_d;
`ifdef MDU_DIV_EN
      div0_q    <= div0_d;
`endif
    end
  end

  assign ready   = (state_q == StIdle);
  assign busy    = ~ready;
  assign done    = (state_q == StDone);
  assign result  = result_q;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_mdu_seq.sv
module tb_mdu_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] op_a, op_b;
  logic        ready, busy, done, illegal;
  logic [31:0] result;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mdu_seq #(
    .DATA_WIDTH(32)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .op      (op),
    .op_a    (op_a),
    .op_b    (op_b),
    .ready   (ready),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .illegal (illegal)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    op = o; op_a = a; op_b = b; start = 1'b1;
  endtask

  // Counts edges from the sampling edge until done is seen (#1 after each edge).
  task automatic wait_done(input int inject, input bit hold, output int lat, output bit busy_ok);
    lat = 0;
    busy_ok = 1'b1;
    do begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1 && !hold) begin
        start = 1'b0; op = 3'($urandom); op_a = $urandom; op_b = $urandom;
      end
      if (inject != 0 && lat == inject) begin
        start = 1'b1; op = 3'b011; op_a = '1; op_b = '1;
      end
      if (inject != 0 && lat == inject + 1) start = 1'b0;
      if (busy !== 1'b1) busy_ok = 1'b0;
    end while (done !== 1'b1 && lat < 100);
  endtask

  task automatic post_done(input string tag, input logic [31:0] exp);
    @(posedge clk); #1;
    chk({tag, " done-1cyc"}, {31'b0, done}, 32'd0);
    chk({tag, " ready-after"}, {31'b0, ready}, 32'd1);
    chk({tag, " result-held"}, result, exp);
  endtask

  task automatic do_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                       input logic exp_ill);
    int lat;
    bit bok;
    drive(o, a, b);
    wait_done(0, 1'b0, lat, bok);
    chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, " result"}, result, exp);
    chk({tag, " illegal"}, {31'b0, illegal}, {31'b0, exp_ill});
    chk({tag, " busy"}, {31'b0, bok}, 32'd1);
    post_done(tag, exp);
  endtask

  task automatic quiet(input string tag, input int n);
    int rises = 0;
    repeat (n) begin
      @(posedge clk); #1;
      if (done === 1'b1) rises++;
    end
    chk({tag, " no-done"}, 32'(rises), 32'd0);
    chk({tag, " ready"}, {31'b0, ready}, 32'd1);
  endtask

  initial begin
    int lat;
    bit bok;
    rst_n = 1'b0; start = 1'b0; op = '0; op_a = '0; op_b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst ready", {31'b0, ready}, 32'd1);
    chk("rst busy", {31'b0, busy}, 32'd0);
    chk("rst done", {31'b0, done}, 32'd0);
    chk("rst illegal", {31'b0, illegal}, 32'd0);
    chk("rst result", result, 32'd0);
    @(negedge clk) rst_n = 1'b1;

    do_op("MUL 7*-3", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 35, 1'b0);
    do_op("MULH min*min", 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 35, 1'b0);
    do_op("MULHU max*max", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 35, 1'b0);
    do_op("MULHSU -1*2", 3'b010, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 35, 1'b0);
    do_op("MULHSU min*max", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 35, 1'b0);
    do_op("MULH -3*5", 3'b001, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 35, 1'b0);
    do_op("MULHU 2^31*4", 3'b011, 32'h8000_0000, 32'd4, 32'd2, 35, 1'b0);
    do_op("MUL 2^16*2^16", 3'b000, 32'h0001_0000, 32'h0001_0000, 32'd0, 35, 1'b0);

`ifdef MDU_DIV_EN
    do_op("DIV ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 35, 1'b0);
    do_op("REM ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 35, 1'b0);
    do_op("DIV -7/2", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 35, 1'b0);
    do_op("REM -7/2", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 35, 1'b0);
    do_op("DIV 7/-2", 3'b100, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 35, 1'b0);
    do_op("REM 7/-2", 3'b110, 32'd7, 32'hFFFF_FFFE, 32'd1, 35, 1'b0);
    do_op("DIVU 5/0", 3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, 35, 1'b0);
    do_op("REMU 5/0", 3'b111, 32'd5, 32'd0, 32'd5, 35, 1'b0);
    do_op("DIV -7/0", 3'b100, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 35, 1'b0);
    do_op("REM -7/0", 3'b110, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 35, 1'b0);
    do_op("DIVU 100/7", 3'b101, 32'd100, 32'd7, 32'd14, 35, 1'b0);
    do_op("REMU 100/7", 3'b111, 32'd100, 32'd7, 32'd2, 35, 1'b0);
`else
    do_op("DIVU illegal", 3'b101, 32'd9, 32'd3, 32'd0, 2, 1'b1);
    do_op("REM illegal", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'd0, 2, 1'b1);
    do_op("MUL after illegal", 3'b000, 32'd6, 32'd7, 32'd42, 35, 1'b0);
`endif

    // A second start mid-CALC must be ignored entirely.
    drive(3'b000, 32'd7, 32'hFFFF_FFFD);
    wait_done(12, 1'b0, lat, bok);
    chk("ignored-start latency", 32'(lat), 32'd35);
    chk("ignored-start result", result, 32'hFFFF_FFEB);
    chk("ignored-start busy", {31'b0, bok}, 32'd1);
    quiet("ignored-start", 40);

    // Reset during CALC aborts the operation.
    drive(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (11) @(posedge clk);
    #1;
    chk("abort busy-before", {31'b0, busy}, 32'd1);
    @(negedge clk);
    rst_n = 1'b0; start = 1'b0;
    #1;
    chk("abort ready", {31'b0, ready}, 32'd1);
    chk("abort busy", {31'b0, busy}, 32'd0);
    chk("abort result", result, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    quiet("abort", 45);
    chk("abort result-after", result, 32'd0);

    // Back-to-back: start held high through done; one IDLE gap before the next op.
    drive(3'b000, 32'd3, 32'd5);
    wait_done(0, 1'b1, lat, bok);
    chk("b2b first latency", 32'(lat), 32'd35);
    chk("b2b first result", result, 32'd15);
    chk("b2b first start-high", {31'b0, start}, 32'd1);
    op = 3'b000; op_a = 32'd11; op_b = 32'd13;
    @(posedge clk); #1;
    chk("b2b gap ready", {31'b0, ready}, 32'd1);
    wait_done(0, 1'b0, lat, bok);
    chk("b2b second latency", 32'(lat), 32'd35);
    chk("b2b second result", result, 32'd143);
    post_done("b2b second", 32'd143);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
